// File: rtl/fp_arith_pkg.sv
// Shared floating-point arithmetic definitions: mantissa width and the
// sequential multiplier state encoding.
package fp_arith_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full-adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mul_add_nb.sv
// WIDTH-bit ripple-carry adder built from fa_cell; carry-in is fixed at 0
// and the final carry-out is exposed for the multiplier accumulator.
module mul_add_nb #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential shift-and-add unsigned mantissa multiplier, one multiplier bit
// per cycle. Define MANT_MUL_NORM_EN to enable the normalized mantissa outputs.
module mant_mul_seq
  import fp_arith_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     mant_out,
  output logic                 norm_shift
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               last;
  logic               load;

  assign addend = mplier[0] ? a_q : '0;

  mul_add_nb #(.WIDTH(WIDTH)) u_add (
    .x    (acc[2*WIDTH-1:WIDTH]),
    .y    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // Add into the upper half, then shift {carry, acc} right: product bits
  // settle into the low half one per cycle.
  assign acc_next = {carry, sum, acc[WIDTH-1:1]};
  assign last     = (cnt == CW'(WIDTH - 1));
  assign load     = start && (state == IDLE || state == DONE);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      state  <= RUN;
      a_q    <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        state   <= DONE;
        product <= acc_next;
      end
    end else begin
      state <= IDLE;
    end
  end

`ifdef MANT_MUL_NORM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_out   <= '0;
      norm_shift <= 1'b0;
    end else if (state == RUN && last) begin
      norm_shift <= acc_next[2*WIDTH-1];
      mant_out   <= acc_next[2*WIDTH-1] ? acc_next[2*WIDTH-1:WIDTH]
                                        : acc_next[2*WIDTH-2:WIDTH-1];
    end
  end
`else
  assign mant_out   = '0;
  assign norm_shift = 1'b0;
`endif

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq against an arithmetic reference model;
// honours MANT_MUL_NORM_EN when computing expected normalization outputs.
module tb_mant_mul_seq;

  localparam int W = 24;
  localparam int MAX_WAIT = 60;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   mant_out;
  logic           norm_shift;

  int errors = 0;
  int checks = 0;

  mant_mul_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .mant_out   (mant_out),
    .norm_shift (norm_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model_product(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  function automatic logic model_norm(input logic [2*W-1:0] p);
`ifdef MANT_MUL_NORM_EN
    return p >= (48'd1 << 47);
`else
    return (p != p);
`endif
  endfunction

  function automatic logic [W-1:0] model_mant(input logic [2*W-1:0] p);
`ifdef MANT_MUL_NORM_EN
    return (p >= (48'd1 << 47)) ? W'(p / (48'd1 << 24)) : W'(p / (48'd1 << 23));
`else
    return W'(p & 48'd0);
`endif
  endfunction

  // Pulse start for one cycle, then scramble the inputs and wait for done.
  // Returns the cycle of done relative to the start edge and the busy count.
  task automatic run_mul(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; a = ai; b = bi;
    lat = -1; busy_cnt = 0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, product, mant_out, norm_shift} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h mant=%h norm=%b, want all zero",
               busy, done, product, mant_out, norm_shift);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi);
    int lat, bc;
    logic [2*W-1:0] exp_p;
    exp_p = model_product(ai, bi);
    run_mul(ai, bi, lat, bc);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, W + 1);
    end
    checks++;
    if (bc !== W) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, W);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL %s_product: a=%h b=%h got %h want %h", name, ai, bi, product, exp_p);
    end
    checks++;
    if (mant_out !== model_mant(exp_p) || norm_shift !== model_norm(exp_p)) begin
      errors++;
      $display("FAIL %s_norm: got mant=%h norm=%b want mant=%h norm=%b",
               name, mant_out, norm_shift, model_mant(exp_p), model_norm(exp_p));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b product=%h, want 0 0 %h",
               name, done, busy, product, exp_p);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_op($sformatf("rand%0d", i), W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_zero_start_while_busy();
    int pulses, first_at;
    pulses = 0; first_at = -1;
    @(negedge clk);
    start = 1'b1; a = '0; b = 24'h123456;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == 10);
      a = (n == 10) ? 24'hABCDEF : '0;
      b = (n == 10) ? 24'h777777 : '0;
      if (done) begin
        pulses++;
        if (first_at < 0) first_at = n;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1 || first_at !== W + 1) begin
      errors++;
      $display("FAIL zero_busy_done: pulses=%0d first=%0d, want 1 at %0d", pulses, first_at, W + 1);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL zero_busy_product: got %h want 0", product);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1;
    int lat2;
    a1 = W'($urandom); b1 = W'($urandom);
    @(negedge clk);
    start = 1'b1; a = a1; b = b1;
    @(negedge clk);
    a = 24'd2; b = 24'd7;
    for (int n = 2; n <= MAX_WAIT && !done; n++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== model_product(a1, b1)) begin
      errors++;
      $display("FAIL b2b_first: done=%b product=%h want 1 %h", done, product, model_product(a1, b1));
    end
    lat2 = -1;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat2 = n;
        break;
      end
    end
    checks++;
    if (lat2 !== W + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, want %0d", lat2, W + 1);
    end
    checks++;
    if (product !== 48'd14) begin
      errors++;
      $display("FAIL b2b_product: got %h want %h", product, 48'd14);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; a = 24'hFFFFFF; b = 24'h00F00F;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, product, mant_out, norm_shift} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h mant=%h norm=%b, want all zero",
               busy, done, product, mant_out, norm_shift);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: saw %0d active cycles after abort, want 0", pulses);
    end
    test_op("after_reset", 24'h00ABCD, 24'h001234);
  endtask

  initial begin
    test_reset();
    test_op("small", 24'd3, 24'd5);
    test_op("max", 24'hFFFFFF, 24'hFFFFFF);
    test_op("min_normal", 24'h800000, 24'h800000);
    test_random();
    test_zero_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mant_mul_seq.md
MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

Interface
- REQ-001 SHALL provide parameter WIDTH, default 24, giving the operand width in bits; the product is 2*WIDTH bits.
- REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows.
- REQ-003 SHALL provide port clk, input, 1 bit: the single clock, rising-edge active.
- REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-005 SHALL provide port start, input, 1 bit: request to begin a multiply.
- REQ-006 SHALL provide port a, input, WIDTH bits: multiplicand, unsigned, sampled with start.
- REQ-007 SHALL provide port b, input, WIDTH bits: multiplier, unsigned, sampled with start.
- REQ-008 SHALL provide port busy, output, 1 bit: a multiply is in progress.
- REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse marking a valid product.
- REQ-010 SHALL provide port product, output, 2*WIDTH bits: a*b, unsigned.
- REQ-011 SHALL provide port mant_out, output, WIDTH bits: normalized mantissa (see Configuration).
- REQ-012 SHALL provide port norm_shift, output, 1 bit: normalization exponent increment (see Configuration).

Function
- REQ-013 SHALL implement three states: IDLE, RUN and DONE.
- REQ-014 In IDLE with start=1 at a rising edge, SHALL latch a and b, clear the accumulator and iteration count, and enter RUN.
- REQ-015 In RUN, each cycle SHALL do the following:
  - if the current multiplier LSB is 1, add the multiplicand to the upper WIDTH accumulator bits, keeping the carry;
  - shift {carry, accumulator} right by one;
  - increment the count.
- REQ-016 After exactly WIDTH RUN cycles, SHALL enter DONE.
- REQ-017 SHALL hold busy=1 throughout RUN and busy=0 otherwise.
- REQ-018 SHALL assert done=1 only in DONE, for exactly one cycle; the first done cycle is WIDTH+1 cycles after the start edge.
- REQ-019 SHALL update product, mant_out and norm_shift on entry to DONE and hold them stable until the next DONE entry or reset.
- REQ-020 From DONE, SHALL return to IDLE if start=0, or re-latch operands and enter RUN directly if start=1 (back-to-back operation).
- REQ-021 SHALL ignore start while in RUN; latched operands SHALL NOT change during RUN.
- REQ-022 SHALL produce an exact, unsigned product with no rounding and no overflow; the full 2*WIDTH bits are always returned.
- REQ-023 Zero operands SHALL take the same full latency as any other operands (no early exit).

Reset
- REQ-024 When rst_n=0, SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, mant_out=0 and norm_shift=0.
- REQ-025 A reset during RUN SHALL abandon the operation with no done pulse; the previous product is cleared.
- REQ-026 On rst_n deassertion, the first accepted start SHALL behave per REQ-014.

Configuration
- REQ-027 With macro MANT_MUL_NORM_EN defined, SHALL drive the normalization outputs in DONE:
  - if product[2*WIDTH-1]=1: norm_shift=1 and mant_out=product[2*WIDTH-1:WIDTH];
  - otherwise: norm_shift=0 and mant_out=product[2*WIDTH-2:WIDTH-1].
- REQ-028 With MANT_MUL_NORM_EN undefined, SHALL tie mant_out and norm_shift to 0 and synthesize no normalization logic; ports SHALL remain present.

Structure
- REQ-029 Package fp_arith_pkg SHALL hold the MANT_W=24 constant and the mul_state_t enum (IDLE, RUN, DONE); the divider and multiplier SHALL share MANT_W.
- REQ-030 The WIDTH-bit add SHALL be one sub-module, mul_add_nb, built as a ripple chain of the existing 1-bit full-adder cell, with carry-in 0 and carry-out exposed.
- REQ-031 The state machine, counter and shift register SHALL reside in mant_mul_seq itself.

Verification
- REQ-032 Small operands: a=3, b=5, start pulsed for 1 cycle -> busy high for 24 cycles, done pulse 25 cycles after the start edge, product=0x00000000000F.
- REQ-033 Maximum operands: a=b=0xFFFFFF -> product=0xFFFFFE000001; with MANT_MUL_NORM_EN: norm_shift=1, mant_out=0xFFFFFE.
- REQ-034 Minimum normal operands: a=b=0x800000 -> product=0x400000000000; with MANT_MUL_NORM_EN: norm_shift=0, mant_out=0x800000; without it: mant_out=0, norm_shift=0.
- REQ-035 Zero and start-while-busy: a=0, b=0x123456 -> product=0 after full latency; start re-pulsed with new operands in cycle 10 of RUN -> ignored, product unchanged, exactly one done pulse.
- REQ-036 Back-to-back: start held high through DONE with new a=2, b=7 -> second done pulse exactly 25 cycles after the first, product=14.
- REQ-037 Reset mid-operation: rst_n low in RUN cycle 12 -> outputs zero immediately, no done pulse; the next start completes normally.
